// File: rtl/parity_frame_checker.sv
// ---------------------------------------------------------------------------
// parity_frame_checker
//
// Multi-lane serial parity checker. A frame is FRAME_BITS data bits followed by
// one parity bit, received in lock-step on CHANNELS lanes. Even or odd parity
// is selected per frame by mode_odd, which is latched along with the accepted
// start. At the end of each frame the checker reports a per-lane error flag
// and keeps a saturating count of frames that had at least one lane in error.
//
// Ports
//   clock     in   1         rising-edge clock
//   reset_n   in   1         asynchronous, active-low reset
//   start     in   1         frame sync; qualified by in_valid, x is data bit 0
//   in_valid  in   1         bit qualifier; start, x and mode_odd ignored when 0
//   x         in   CHANNELS  serial bit per lane
//   mode_odd  in   1         0 = even parity, 1 = odd parity
//   err_clr   in   1         synchronous clear of err_cnt
//   z         out  CHANNELS  parity bit that would complete the frame if x
//                            were the last data bit (combinational)
//   busy      out  1         frame in progress
//   done      out  1         one-cycle pulse after the parity bit is accepted
//   err       out  CHANNELS  per-lane error of the last completed frame
//   err_cnt   out  CNT_W     saturating count of frames with any error
//
// States
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | no frame in progress, waiting for a qualified start
//   S_DATA  | accumulating data bits 1 .. FRAME_BITS-1
//   S_CHECK | next qualified bit is the parity bit
// ---------------------------------------------------------------------------
module parity_frame_checker #(
    parameter int CHANNELS   = 1,
    parameter int FRAME_BITS = 8,
    parameter int CNT_W      = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                in_valid,
    input  logic [CHANNELS-1:0] x,
    input  logic                mode_odd,
    input  logic                err_clr,
    output logic [CHANNELS-1:0] z,
    output logic                busy,
    output logic                done,
    output logic [CHANNELS-1:0] err,
    output logic [CNT_W-1:0]    err_cnt
);

    // Bit counter only needs to reach FRAME_BITS-1; keep at least one bit so
    // the single-bit-frame configuration still elaborates.
    localparam int CNT_BITS = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [CNT_BITS-1:0] LAST_DATA = CNT_BITS'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t                state;
    logic [CHANNELS-1:0]   par;
    logic [CNT_BITS-1:0]   cnt;
    logic                  mode_q;

    logic                  accept_start;
    logic                  accept_parity;
    logic [CHANNELS-1:0]   new_err;
    logic                  bad_frame;

    assign busy          = (state != S_IDLE);
    assign accept_start  = in_valid & start;
    assign accept_parity = in_valid & ~start & (state == S_CHECK);

    // In CHECK, x is the received parity bit; a lane is bad when the data
    // ones plus the parity bit do not match the latched parity sense.
    assign new_err   = par ^ x ^ {CHANNELS{mode_q}};
    assign bad_frame = |new_err;

    // Outside a frame the prediction assumes x would be a one-bit frame using
    // the live mode input, since mode_q has not been loaded yet.
    assign z = (busy ? par : {CHANNELS{1'b0}}) ^ x
             ^ {CHANNELS{(busy ? mode_q : mode_odd)}};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            par     <= '0;
            cnt     <= '0;
            mode_q  <= 1'b0;
            done    <= 1'b0;
            err     <= '0;
            err_cnt <= '0;
        end else begin
            done <= 1'b0;

            // A qualified start always opens a new frame, silently dropping
            // any frame still in progress (no done, err untouched).
            if (accept_start) begin
                par    <= x;
                mode_q <= mode_odd;
                cnt    <= CNT_BITS'(1);
                state  <= (FRAME_BITS == 1) ? S_CHECK : S_DATA;
            end else if (in_valid) begin
                case (state)
                    S_DATA: begin
                        par <= par ^ x;
                        if (cnt == LAST_DATA) begin
                            state <= S_CHECK;
                        end else begin
                            cnt <= cnt + CNT_BITS'(1);
                        end
                    end
                    S_CHECK: begin
                        err   <= new_err;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end

            if (err_clr) begin
                err_cnt <= '0;
            end else if (accept_parity && bad_frame && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
module tb_parity_frame_checker;

    localparam int CH = 2;
    localparam int FB = 8;

    logic          clock    = 1'b0;
    logic          reset_n  = 1'b0;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic [CH-1:0] x        = '0;
    logic          mode_odd = 1'b0;
    logic          err_clr  = 1'b0;

    logic [CH-1:0] z, z_s;
    logic          busy, busy_s, done, done_s;
    logic [CH-1:0] err, err_s;
    logic [7:0]    err_cnt;
    logic [1:0]    err_cnt_s;

    parity_frame_checker #(.CHANNELS(CH), .FRAME_BITS(FB), .CNT_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .x(x), .mode_odd(mode_odd), .err_clr(err_clr),
        .z(z), .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
    );

    parity_frame_checker #(.CHANNELS(CH), .FRAME_BITS(FB), .CNT_W(2)) dut_s (
        .clock(clock), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .x(x), .mode_odd(mode_odd), .err_clr(err_clr),
        .z(z_s), .busy(busy_s), .done(done_s), .err(err_s), .err_cnt(err_cnt_s)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: counts ones per lane over the frame.
    bit            m_in_frame;
    int            m_nbits;
    int            m_ones [CH];
    bit            m_mode;
    bit [CH-1:0]   m_err;
    bit            m_done;
    int            m_cnt8, m_cnt2;

    logic [CH-1:0] z_seen, z_seen_s, z_exp;

    function automatic void model_reset();
        m_in_frame = 0; m_nbits = 0; m_mode = 0;
        m_err = '0; m_done = 0; m_cnt8 = 0; m_cnt2 = 0;
        for (int c = 0; c < CH; c++) m_ones[c] = 0;
    endfunction

    function automatic logic [CH-1:0] model_z(logic [CH-1:0] xx, logic m);
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) begin
            if (m_in_frame) r[c] = ((m_ones[c] + int'(xx[c]) + int'(m_mode)) % 2) == 1;
            else            r[c] = ((int'(xx[c]) + int'(m)) % 2) == 1;
        end
        return r;
    endfunction

    function automatic void model_clock(logic s, logic v, logic [CH-1:0] xx, logic m, logic c);
        bit parity_accept = 0;
        m_done = 0;
        if (v && s) begin
            m_in_frame = 1; m_nbits = 1; m_mode = m;
            for (int k = 0; k < CH; k++) m_ones[k] = int'(xx[k]);
        end else if (v && m_in_frame) begin
            if (m_nbits < FB) begin
                for (int k = 0; k < CH; k++) m_ones[k] += int'(xx[k]);
                m_nbits++;
            end else begin
                for (int k = 0; k < CH; k++)
                    m_err[k] = ((m_ones[k] + int'(xx[k]) + int'(m_mode)) % 2) == 1;
                m_done = 1;
                parity_accept = 1;
                m_in_frame = 0;
            end
        end
        if (c) begin
            m_cnt8 = 0; m_cnt2 = 0;
        end else if (parity_accept && (m_err != '0)) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3)   m_cnt2++;
        end
    endfunction

    // Drive one cycle: inputs set on the falling edge, z sampled before the
    // rising edge, registered outputs settle 1 time unit after it.
    task automatic tick(input logic s, input logic v, input logic [CH-1:0] xx,
                        input logic m, input logic c);
        @(negedge clock);
        start = s; in_valid = v; x = xx; mode_odd = m; err_clr = c;
        #1;
        z_seen   = z;
        z_seen_s = z_s;
        z_exp    = model_z(xx, m);
        @(posedge clock);
        model_clock(s, v, xx, m, c);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if ({busy, done, err, err_cnt, err_cnt_s} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs got busy=%b done=%b err=%b cnt=%0d cnt_s=%0d exp all 0",
                     busy, done, err, err_cnt, err_cnt_s);
        end
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_even_frame();
        logic [7:0] d0 = 8'b1011_0010;
        logic [7:0] d1 = 8'b0000_0001;
        for (int i = 7; i >= 0; i--) begin
            tick(i == 7, 1'b1, {d1[i], d0[i]}, 1'b0, 1'b0);
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL even_data_busy bit=%0d got busy=%b done=%b exp busy=1 done=0", i, busy, done);
            end
        end
        tick(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (done !== 1'b1 || err !== 2'b10 || err_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL even_result got done=%b err=%b cnt=%0d exp done=1 err=10 cnt=1", done, err, err_cnt);
        end
        tick(1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
        n_checks++;
        if (done !== 1'b0 || err !== 2'b10 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL even_after got done=%b err=%b busy=%b exp done=0 err=10 busy=0", done, err, busy);
        end
    endtask

    task automatic test_odd_frame();
        logic [7:0] d0 = 8'b1011_0010;
        for (int pass = 0; pass < 2; pass++) begin
            logic m = (pass == 0);
            for (int i = 7; i >= 0; i--) begin
                tick(i == 7, 1'b1, {1'b0, d0[i]}, m, 1'b0);
                if (i == 0) begin
                    n_checks++;
                    if (z_seen[0] !== m || z_seen !== z_exp) begin
                        n_errors++;
                        $display("FAIL z_last_bit mode_odd=%b got z=%b exp z=%b", m, z_seen, z_exp);
                    end
                end
            end
            tick(1'b0, 1'b1, {m, m}, 1'b0, 1'b0);
            n_checks++;
            if (done !== 1'b1 || err !== 2'b00 || err_cnt !== 8'd1) begin
                n_errors++;
                $display("FAIL parity_mode mode_odd=%b got done=%b err=%b cnt=%0d exp done=1 err=00 cnt=1",
                         m, done, err, err_cnt);
            end
        end
    endtask

    task automatic test_gap();
        logic [7:0] d0 = 8'b1011_0010;
        logic [7:0] d1 = 8'b0000_0001;
        for (int i = 7; i >= 4; i--) tick(i == 7, 1'b1, {d1[i], d0[i]}, 1'b0, 1'b0);
        for (int g = 0; g < 3; g++) begin
            tick(1'b1, 1'b0, CH'($urandom_range(0, 3)), 1'b1, 1'b0);
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL gap_busy cycle=%0d got busy=%b done=%b exp busy=1 done=0", g, busy, done);
            end
        end
        for (int i = 3; i >= 0; i--) tick(1'b0, 1'b1, {d1[i], d0[i]}, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (done !== 1'b1 || err !== 2'b10 || err_cnt !== 8'd2) begin
            n_errors++;
            $display("FAIL gap_result got done=%b err=%b cnt=%0d exp done=1 err=10 cnt=2", done, err, err_cnt);
        end
    endtask

    task automatic test_abort_back_to_back();
        logic [7:0] d0 = 8'b1011_0010;
        logic [7:0] d1 = 8'b0000_0001;
        for (int i = 7; i >= 3; i--) tick(i == 7, 1'b1, {d0[i], d1[i]}, 1'b1, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            tick(i == 7, 1'b1, {d1[i], d0[i]}, 1'b0, 1'b0);
            n_checks++;
            if (done !== 1'b0) begin
                n_errors++;
                $display("FAIL abort_no_done bit=%0d got done=%b exp done=0", i, done);
            end
        end
        tick(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (done !== 1'b1 || err !== 2'b10 || err_cnt !== 8'd3) begin
            n_errors++;
            $display("FAIL abort_new_frame got done=%b err=%b cnt=%0d exp done=1 err=10 cnt=3", done, err, err_cnt);
        end
        // Frame A starts in the done cycle of the previous frame; good parity.
        for (int i = 7; i >= 0; i--) tick(i == 7, 1'b1, {d1[i], d0[i]}, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
        n_checks++;
        if (done !== 1'b1 || err !== 2'b00 || err_cnt !== 8'd3) begin
            n_errors++;
            $display("FAIL b2b_frame_a got done=%b err=%b cnt=%0d exp done=1 err=00 cnt=3", done, err, err_cnt);
        end
        // Frame B, zero gap, odd mode: lane0 wrong parity, lane1 right.
        for (int i = 7; i >= 0; i--) begin
            tick(i == 7, 1'b1, {d1[i], d0[i]}, 1'b1, 1'b0);
            if (i == 7) begin
                n_checks++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b_start got done=%b busy=%b exp done=0 busy=1", done, busy);
                end
            end
        end
        tick(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (done !== 1'b1 || err !== 2'b01 || err_cnt !== 8'd4 || err_cnt_s !== 2'd3) begin
            n_errors++;
            $display("FAIL b2b_frame_b got done=%b err=%b cnt=%0d cnt_s=%0d exp done=1 err=01 cnt=4 cnt_s=3",
                     done, err, err_cnt, err_cnt_s);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] d0 = 8'b1011_0010;
        logic [7:0] d1 = 8'b0000_0001;
        tick(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        n_checks++;
        if (err_cnt !== 8'd0 || err_cnt_s !== 2'd0) begin
            n_errors++;
            $display("FAIL sat_clear got cnt=%0d cnt_s=%0d exp 0 0", err_cnt, err_cnt_s);
        end
        for (int f = 1; f <= 5; f++) begin
            for (int i = 7; i >= 0; i--) tick(i == 7, 1'b1, {d1[i], d0[i]}, 1'b0, 1'b0);
            tick(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
            n_checks++;
            if (err_cnt !== 8'(f) || err_cnt_s !== 2'((f > 3) ? 3 : f)) begin
                n_errors++;
                $display("FAIL sat_count frame=%0d got cnt=%0d cnt_s=%0d exp cnt=%0d cnt_s=%0d",
                         f, err_cnt, err_cnt_s, f, (f > 3) ? 3 : f);
            end
        end
        for (int i = 7; i >= 0; i--) tick(i == 7, 1'b1, {d1[i], d0[i]}, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
        n_checks++;
        if (err_cnt !== 8'd0 || err_cnt_s !== 2'd0 || err !== 2'b10 || done !== 1'b1) begin
            n_errors++;
            $display("FAIL clr_priority got cnt=%0d cnt_s=%0d err=%b done=%b exp 0 0 10 1",
                     err_cnt, err_cnt_s, err, done);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] d0 = 8'b1011_0010;
        logic [7:0] d1 = 8'b0000_0001;
        for (int i = 7; i >= 0; i--) tick(i == 7, 1'b1, {d1[i], d0[i]}, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        for (int i = 7; i >= 5; i--) tick(i == 7, 1'b1, {d1[i], d0[i]}, 1'b0, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || err !== 2'b10 || err_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL pre_reset got busy=%b err=%b cnt=%0d exp busy=1 err=10 cnt=1", busy, err, err_cnt);
        end
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({busy, done, err, err_cnt, err_cnt_s} !== '0) begin
            n_errors++;
            $display("FAIL async_reset got busy=%b done=%b err=%b cnt=%0d cnt_s=%0d exp all 0",
                     busy, done, err, err_cnt, err_cnt_s);
        end
        @(negedge clock);
        reset_n = 1'b1;
        tick(1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_idle got busy=%b done=%b exp busy=0 done=0", busy, done);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            logic s = ($urandom_range(0, 15) == 0);
            logic v = ($urandom_range(0, 3) != 0);
            logic c = ($urandom_range(0, 59) == 0);
            tick(s, v, CH'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), c);
            n_checks++;
            if (z_seen !== z_exp || z_seen_s !== z_exp) begin
                n_errors++;
                $display("FAIL rand_z cycle=%0d got z=%b z_s=%b exp z=%b", n, z_seen, z_seen_s, z_exp);
            end
            n_checks++;
            if (busy !== m_in_frame || done !== m_done || err !== m_err
                || busy_s !== m_in_frame || done_s !== m_done || err_s !== m_err) begin
                n_errors++;
                $display("FAIL rand_state cycle=%0d got busy=%b done=%b err=%b exp busy=%b done=%b err=%b",
                         n, busy, done, err, m_in_frame, m_done, m_err);
            end
            n_checks++;
            if (err_cnt !== 8'(m_cnt8) || err_cnt_s !== 2'(m_cnt2)) begin
                n_errors++;
                $display("FAIL rand_cnt cycle=%0d got cnt=%0d cnt_s=%0d exp cnt=%0d cnt_s=%0d",
                         n, err_cnt, err_cnt_s, m_cnt8, m_cnt2);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_even_frame();
        test_odd_frame();
        test_gap();
        test_abort_back_to_back();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
